// File: rtl/fir_mac_seq_pkg.sv
// Shared types and constants for the FIR multiply-accumulate sequencer.
package fir_mac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int MUL_LAT_DEF = 3;
  localparam int SAT_MAX     = 32767;
  localparam int SAT_MIN     = -32768;

  function automatic logic [16:0] sext17(input logic [15:0] x);
    return {x[15], x};
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Sample history ring: one write port, combinational read by index.
module fir_sample_ring #(
  parameter int TAPS  = 16,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [15:0]      rdata
);

  // Contents are never reset; stale entries are masked by the fill count upstream.
  logic [15:0] ring_reg [TAPS];

  always_ff @(posedge clk) begin
    if (we) begin
      ring_reg[waddr] <= wdata;
    end
  end

  assign rdata = ring_reg[raddr];

endmodule

// File: rtl/fir_mac_seq.sv
// Sequences TAPS sample*coefficient pairs through an external multiplier pipeline,
// accumulates the products and emits one rounded, saturated 16-bit result per input.
module fir_mac_seq
  import fir_mac_seq_pkg::*;
#(
  parameter int TAPS    = 16,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [15:0]             s_data,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [16:0]             coef_data,
  output logic                    mul_ce,
  output logic [16:0]             mul_a,
  output logic [16:0]             mul_b,
  input  logic [33:0]             mul_p,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [15:0]             m_data,
  output logic                    m_sat
);

  localparam int IDX_W = $clog2(TAPS);
  localparam int DRN_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic signed [ACC_W-1:0] ROUND  = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] HI_LIM = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO_LIM = ACC_W'(SAT_MIN);

  state_t                   state_reg;
  logic [IDX_W-1:0]         wr_ptr_reg;
  logic [IDX_W:0]           fill_reg;
  logic [IDX_W-1:0]         tap_reg;
  logic [DRN_W-1:0]         drain_cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [MUL_LAT-1:0]       tag_reg;
  logic                     m_valid_reg;
  logic [15:0]              m_data_reg;
  logic                     m_sat_reg;

  logic                     issuing;
  logic                     tap_live;
  logic                     ring_we;
  logic [IDX_W-1:0]         rd_idx;
  logic [15:0]              ring_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  rounded;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [15:0]              sat_data;

  assign issuing  = (state_reg == ST_ISSUE);
  assign s_ready  = (state_reg == ST_IDLE) && !rst;
  assign ring_we  = s_valid && s_ready;
  assign rd_idx   = wr_ptr_reg - tap_reg;
  // Taps reaching past the samples seen since reset contribute zero.
  assign tap_live = ({1'b0, tap_reg} < fill_reg);

  fir_sample_ring #(
    .TAPS  (TAPS),
    .IDX_W (IDX_W)
  ) u_ring (
    .clk   (clk),
    .we    (ring_we),
    .waddr (wr_ptr_reg),
    .wdata (s_data),
    .raddr (rd_idx),
    .rdata (ring_q)
  );

  assign coef_addr = tap_reg;
  assign mul_ce    = issuing || (state_reg == ST_DRAIN);
  assign mul_a     = (issuing && tap_live) ? sext17(ring_q) : '0;
  assign mul_b     = issuing ? coef_data : '0;

  // The final product lands on the same edge that enters OUT, so the output
  // path works from the post-add value rather than acc_reg.
  assign prod_ext = ACC_W'($signed(mul_p));
  assign acc_sum  = tag_reg[MUL_LAT-1] ? (acc_reg + prod_ext) : acc_reg;
  assign acc_rnd  = acc_sum + ROUND;
  assign rounded  = acc_rnd >>> SHIFT;
  assign sat_hi   = (rounded > HI_LIM);
  assign sat_lo   = (rounded < LO_LIM);

  always_comb begin
    sat_data = rounded[15:0];
    if (sat_hi) begin
      sat_data = 16'(SAT_MAX);
    end else if (sat_lo) begin
      sat_data = 16'(SAT_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      fill_reg      <= '0;
      tap_reg       <= '0;
      drain_cnt_reg <= '0;
      acc_reg       <= '0;
      tag_reg       <= '0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      m_sat_reg     <= 1'b0;
    end else begin
      tag_reg <= MUL_LAT'({tag_reg, issuing});
      acc_reg <= acc_sum;
      case (state_reg)
        ST_IDLE: begin
          if (s_valid) begin
            state_reg <= ST_ISSUE;
            tap_reg   <= '0;
            acc_reg   <= '0;
            if (fill_reg != (IDX_W+1)'(TAPS)) begin
              fill_reg <= fill_reg + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (tap_reg == IDX_W'(TAPS - 1)) begin
            state_reg     <= ST_DRAIN;
            tap_reg       <= '0;
            drain_cnt_reg <= '0;
          end else begin
            tap_reg <= tap_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == DRN_W'(MUL_LAT - 1)) begin
            state_reg   <= ST_OUT;
            wr_ptr_reg  <= wr_ptr_reg + 1'b1;
            m_valid_reg <= 1'b1;
            m_data_reg  <= sat_data;
            m_sat_reg   <= sat_hi || sat_lo;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_sat   = m_sat_reg;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomised scoreboard bench for fir_mac_seq with a 3-stage 17x17 multiplier and coefficient file.
module tb_fir_mac_seq;

  localparam int TAPS = 16;
  localparam int LAT  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [3:0]  coef_addr;
  logic [16:0] coef_data;
  logic        mul_ce;
  logic [16:0] mul_a;
  logic [16:0] mul_b;
  logic [33:0] mul_p;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_sat;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;
  int coef [TAPS];
  int hist [$];
  int exp_d [$];
  bit exp_s [$];
  int hs_q [$];

  logic signed [33:0] p1, p2, p3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign coef_data = 17'(coef[coef_addr]);

  always @(posedge clk) begin
    if (mul_ce) begin
      p1 <= $signed(mul_a) * $signed(mul_b);
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign mul_p = p3;

  fir_mac_seq dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .mul_ce    (mul_ce),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sat     (m_sat)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Direct-form FIR over the last TAPS samples since reset, round half up, clamp.
  task automatic model(input int x, output int d, output bit s);
    longint sum = 0;
    longint r;
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
    for (int k = 0; k < hist.size(); k++) sum += longint'(hist[k]) * longint'(coef[k]);
    r = (sum + 16384) >>> 15;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    if (r < -32768) begin r = -32768; s = 1'b1; end
    d = int'(r);
  endtask

  task automatic send(input int x);
    int waitc = 0;
    int d;
    bit s;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 16'(x);
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waitc++;
      if (waitc > 200) begin
        check("send_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
    end
    hs_q.push_back(cyc);
    model(x, d, s);
    exp_d.push_back(d);
    exp_s.push_back(s);
    $display("in  x=%0d expect=%0d sat=%0d", x, d, s);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waitc = 0;
    forever begin
      @(negedge clk);
      if (exp_d.size() == 0 && s_ready) break;
      waitc++;
      if (waitc > 3000) begin
        check("drain_timeout", exp_d.size(), 0);
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    hist.delete();
    exp_d.delete();
    exp_s.delete();
    hs_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("s_ready_in_rst", s_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int step, input int rest);
    for (int k = 0; k < TAPS; k++) coef[k] = (k == 0) ? c0 : rest + step * k;
  endtask

  // Monitor: latency on m_valid rise, data/sat on every output handshake.
  initial begin
    bit prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid && !prev_mv) begin
        if (hs_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency", cyc - hs_q.pop_front(), LAT);
      end
      if (m_valid && m_ready) begin
        if (exp_d.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          int d;
          bit s;
          d = exp_d.pop_front();
          s = exp_s.pop_front();
          $display("out m_data=%0d exp=%0d m_sat=%0d exp=%0d", $signed(m_data), d, m_sat, s);
          check("m_data", longint'($signed(m_data)), d);
          check("m_sat", m_sat, s);
        end
      end
      prev_mv = m_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_coefs(0, 0, 0);
    do_reset();
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_mul_ce", mul_ce, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_coef_addr", coef_addr, 0);

    // Unity
    set_coefs(32768, 0, 0);
    send(1234);
    wait_idle();

    // Impulse through ramp coefficients
    do_reset();
    for (int k = 0; k < TAPS; k++) coef[k] = 2048 * k;
    send(16384);
    for (int i = 1; i < TAPS; i++) send(0);
    wait_idle();

    // Saturation both directions
    do_reset();
    set_coefs(32768, 0, 32768);
    send(32767);
    send(32767);
    for (int i = 0; i < TAPS; i++) send(-32768);
    wait_idle();

    // Backpressure: output held, no new input, multiplier idle
    begin
      logic [15:0] held;
      int waitc = 0;
      m_ready = 1'b0;
      send(-5000);
      while (!m_valid && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      check("bp_valid_seen", m_valid, 1);
      held = m_data;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("bp_stable", {m_valid, m_data, s_ready, mul_ce}, {1'b1, held, 1'b0, 1'b0});
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_idle();
    end

    // Reset in the middle of the issue phase
    begin
      int waitc = 0;
      int seen = 0;
      send(7777);
      forever begin
        @(negedge clk);
        if (mul_ce && coef_addr == 4'd5) break;
        waitc++;
        if (waitc > 100) begin
          check("issue_k5_timeout", 0, 1);
          break;
        end
      end
      do_reset();
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (m_valid) seen++;
      end
      check("abort_no_valid", seen, 0);
      set_coefs(32768, 0, 1000);
      send(500);
      wait_idle();
    end

    // Rounding at the half-LSB boundary
    do_reset();
    set_coefs(1, 0, 0);
    send(16384);
    send(-16384);
    send(-16385);
    wait_idle();

    // Random samples, wide and narrow coefficients, random backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < TAPS; k++) coef[k] = int'($urandom_range(0, 131071)) - 65536;
    for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 65535)) - 32768);
    wait_idle();
    for (int k = 0; k < TAPS; k++) coef[k] = int'($urandom_range(0, 8191)) - 4096;
    for (int i = 0; i < 24; i++) send(int'($urandom_range(0, 65535)) - 32768);
    wait_idle();
    rand_rdy = 1'b0;
    m_ready = 1'b1;

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
